tdc_edge_decoder_pipe: RTL and testbench

Pipelined, parametrised edge decoder for the TDC delay-line snapshot. On a single-cycle `go`, it captures the tap vector and finds every qualified thermometer edge, using a configurable confirmation window. It reports the first edge, the last edge, the edge count and bubble/error status, then pulses `finished`. It sits between the delay-line capture registers and the coarse/fine time combiner, one instance per start/stop channel.

---
 rtl/tdc_edge_decoder_pipe.sv | 174 +++++++++++++++++
 tb/tb_tdc_edge_decoder_pipe.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_edge_decoder_pipe.sv
// Pipelined TDC thermometer edge decoder: capture, match-mask, encode.
// Ports: clk, rst (sync active-low), go, wDecodeIn -> busy, finished, positions, count, flags.
module tdc_edge_decoder_pipe #(
  parameter int NUM_TAPS   = 36,
  parameter int NUM_DECODE = 8,
  parameter int WIN        = 4,
  parameter int FALLING    = 0,
  parameter int MODE       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [NUM_TAPS-1:0]   wDecodeIn,
  output logic                  busy,
  output logic                  finished,
  output logic [NUM_DECODE-1:0] wDecodeOut,
  output logic [NUM_DECODE-1:0] first_pos,
  output logic [NUM_DECODE-1:0] last_pos,
  output logic [NUM_DECODE-1:0] edge_count,
  output logic                  no_edge,
  output logic                  multi_edge,
  output logic                  overrun
);

  localparam int   M   = NUM_TAPS - WIN;
  localparam int   ND  = NUM_DECODE;
  localparam int   CW  = NUM_DECODE + 1;
  // Level expected in the confirming taps; edge tap is the opposite.
  localparam logic POL = (FALLING != 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DETECT = 2'd1,
    S_ENCODE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_TAPS-1:0] snap_q, snap_d;
  logic [M-1:0]        mask_q, mask_d;
  logic                busy_q, busy_d;
  logic                fin_q, fin_d;
  logic [ND-1:0]       out_q, out_d;
  logic [ND-1:0]       first_q, first_d;
  logic [ND-1:0]       last_q, last_d;
  logic [ND-1:0]       cnt_q, cnt_d;
  logic                none_q, none_d;
  logic                multi_q, multi_d;
  logic                ovr_q, ovr_d;

  logic [M-1:0]  match;
  logic [ND-1:0] first_c, last_c, cnt_sat, mid_c, sel_c;
  logic [CW-1:0] cnt_c, sum_c;

  always_comb begin
    match = '0;
    for (int i = 0; i < M; i++) begin
      match[i] = (snap_q[i] != POL);
      for (int k = 1; k <= WIN; k++) begin
        match[i] = match[i] & (snap_q[i+k] == POL);
      end
    end
  end

  always_comb begin
    first_c = '0;
    last_c  = '0;
    cnt_c   = '0;
    for (int i = M - 1; i >= 0; i--) begin
      if (mask_q[i]) first_c = ND'(i + 1);
    end
    for (int i = 0; i < M; i++) begin
      if (mask_q[i]) begin
        last_c = ND'(i + 1);
        cnt_c  = cnt_c + CW'(1);
      end
    end
  end

  assign cnt_sat = cnt_c[ND] ? '1 : cnt_c[ND-1:0];
  assign sum_c   = {1'b0, first_c} + {1'b0, last_c};
  assign mid_c   = ND'(sum_c >> 1);

  always_comb begin
    sel_c = last_c;
    if (MODE == 1) sel_c = first_c;
    if (MODE == 2) sel_c = mid_c;
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    mask_d  = mask_q;
    busy_d  = busy_q;
    fin_d   = 1'b0;
    out_d   = out_q;
    first_d = first_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    none_d  = none_q;
    multi_d = multi_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          snap_d  = wDecodeIn;
          busy_d  = 1'b1;
          state_d = S_DETECT;
        end
      end
      S_DETECT: begin
        if (go) ovr_d = 1'b1;
        mask_d  = match;
        state_d = S_ENCODE;
      end
      S_ENCODE: begin
        if (go) ovr_d = 1'b1;
        first_d = first_c;
        last_d  = last_c;
        cnt_d   = cnt_sat;
        out_d   = sel_c;
        none_d  = (cnt_c == '0);
        multi_d = (cnt_c >= CW'(2));
        fin_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      snap_q  <= '0;
      mask_q  <= '0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
      out_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      none_q  <= 1'b0;
      multi_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      mask_q  <= mask_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
      out_q   <= out_d;
      first_q <= first_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      none_q  <= none_d;
      multi_q <= multi_d;
      ovr_q   <= ovr_d;
    end
  end

  assign busy       = busy_q;
  assign finished   = fin_q;
  assign wDecodeOut = out_q;
  assign first_pos  = first_q;
  assign last_pos   = last_q;
  assign edge_count = cnt_q;
  assign no_edge    = none_q;
  assign multi_edge = multi_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_tdc_edge_decoder_pipe.sv
// Directed bench for tdc_edge_decoder_pipe.
// Three instances: start/last, start WIN=2/midpoint, stop/first.
module tb_tdc_edge_decoder_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic [35:0] wdi;

  logic       busy[3];
  logic       fin[3];
  logic [7:0] dout[3];
  logic [7:0] fpos[3];
  logic [7:0] lpos[3];
  logic [7:0] cnt[3];
  logic       none[3];
  logic       multi[3];
  logic       ovr[3];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tdc_edge_decoder_pipe #(
    .WIN(4), .FALLING(0), .MODE(0)
  ) u_a (
    .clk(clk), .rst(rst), .go(go), .wDecodeIn(wdi),
    .busy(busy[0]), .finished(fin[0]),
    .wDecodeOut(dout[0]), .first_pos(fpos[0]),
    .last_pos(lpos[0]), .edge_count(cnt[0]),
    .no_edge(none[0]), .multi_edge(multi[0]),
    .overrun(ovr[0])
  );

  tdc_edge_decoder_pipe #(
    .WIN(2), .FALLING(0), .MODE(2)
  ) u_b (
    .clk(clk), .rst(rst), .go(go), .wDecodeIn(wdi),
    .busy(busy[1]), .finished(fin[1]),
    .wDecodeOut(dout[1]), .first_pos(fpos[1]),
    .last_pos(lpos[1]), .edge_count(cnt[1]),
    .no_edge(none[1]), .multi_edge(multi[1]),
    .overrun(ovr[1])
  );

  tdc_edge_decoder_pipe #(
    .WIN(4), .FALLING(1), .MODE(1)
  ) u_c (
    .clk(clk), .rst(rst), .go(go), .wDecodeIn(wdi),
    .busy(busy[2]), .finished(fin[2]),
    .wDecodeOut(dout[2]), .first_pos(fpos[2]),
    .last_pos(lpos[2]), .edge_count(cnt[2]),
    .no_edge(none[2]), .multi_edge(multi[2]),
    .overrun(ovr[2])
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Pulse go in cycle 0; returns at the cycle-3 sample point.
  task automatic run_decode(input logic [35:0] t);
    go  = 1'b1;
    wdi = t;
    tick();
    go = 1'b0;
    chk("busy_c1", busy[0], 1);
    chk("fin_c1", fin[0], 0);
    tick();
    chk("busy_c2", busy[0], 1);
    chk("fin_c2", fin[0], 0);
    tick();
    chk("fin_c3", fin[0], 1);
    chk("busy_c3", busy[0], 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    go  = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    go  = 1'b0;
    wdi = '0;
    tick();
    do_reset();

    chk("rst_busy", busy[0], 0);
    chk("rst_fin", fin[0], 0);
    chk("rst_ovr", ovr[0], 0);
    chk("rst_none", none[0], 0);
    chk("rst_out", dout[0], 0);
    chk("rst_first", fpos[0], 0);
    chk("rst_last", lpos[0], 0);
    chk("rst_cnt", cnt[0], 0);
    chk("rst_multi", multi[0], 0);

    // Clean start edge at tap 9
    run_decode(36'h0_0000_03FF);
    chk("clean_first", fpos[0], 10);
    chk("clean_last", lpos[0], 10);
    chk("clean_out", dout[0], 10);
    chk("clean_cnt", cnt[0], 1);
    chk("clean_none", none[0], 0);
    chk("clean_multi", multi[0], 0);
    chk("clean_b_out", dout[1], 10);
    chk("clean_c_none", none[2], 1);
    chk("clean_c_first", fpos[2], 0);
    tick();
    chk("clean_fin_c4", fin[0], 0);

    // Bubble: matches at 5 and 12 for WIN=2
    run_decode(36'h0_0000_1E3F);
    chk("bub_first", fpos[1], 6);
    chk("bub_last", lpos[1], 13);
    chk("bub_cnt", cnt[1], 2);
    chk("bub_multi", multi[1], 1);
    chk("bub_mid", dout[1], 9);
    chk("bub_none", none[1], 0);
    chk("bub_a_first", fpos[0], 13);
    chk("bub_a_cnt", cnt[0], 1);
    chk("bub_a_multi", multi[0], 0);
    tick();

    // Edge too close to the top end
    run_decode(36'h7_FFFF_FFFF);
    chk("end_none", none[0], 1);
    chk("end_first", fpos[0], 0);
    chk("end_last", lpos[0], 0);
    chk("end_cnt", cnt[0], 0);
    chk("end_out", dout[0], 0);
    chk("end_multi", multi[0], 0);
    tick();

    // Stop mode: 0 at tap 19 then ones
    run_decode(36'hF_FFF0_0000);
    chk("stop_first", fpos[2], 20);
    chk("stop_out", dout[2], 20);
    chk("stop_last", lpos[2], 20);
    chk("stop_cnt", cnt[2], 1);
    chk("stop_none", none[2], 0);
    chk("stop_a_none", none[0], 1);
    tick();
    chk("pre_ovr", ovr[0], 0);

    // Handshake: go in cycles 0 and 1, taps toggled in 1-2
    go  = 1'b1;
    wdi = 36'h0_0000_03FF;
    tick();
    chk("hs_ovr_c1", ovr[0], 0);
    wdi = 36'h0_0000_FFFF;
    tick();
    go  = 1'b0;
    wdi = 36'h0;
    chk("hs_ovr_c2", ovr[0], 1);
    chk("hs_fin_c2", fin[0], 0);
    tick();
    chk("hs_fin_c3", fin[0], 1);
    chk("hs_first", fpos[0], 10);
    chk("hs_cnt", cnt[0], 1);
    go  = 1'b1;
    wdi = 36'h0_0000_1E3F;
    tick();
    go = 1'b0;
    chk("hs_fin_c4", fin[0], 0);
    chk("hs_busy_c4", busy[0], 1);
    chk("hs_ovr_c4", ovr[0], 1);
    tick();
    chk("hs_fin_c5", fin[0], 0);
    tick();
    chk("hs_fin_c6", fin[0], 1);
    chk("hs2_a_first", fpos[0], 13);
    chk("hs2_b_first", fpos[1], 6);
    chk("hs2_b_mid", dout[1], 9);
    tick();
    chk("hs_fin_c7", fin[0], 0);
    chk("hs_ovr_sticky", ovr[0], 1);

    // Reset mid-decode
    do_reset();
    chk("rr_ovr", ovr[0], 0);
    go  = 1'b1;
    wdi = 36'h0_0000_03FF;
    tick();
    go = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("rr_fin_c3", fin[0], 0);
    chk("rr_busy_c3", busy[0], 0);
    chk("rr_first_c3", fpos[1], 0);
    chk("rr_out_c3", dout[1], 0);
    rst = 1'b1;
    tick();
    chk("rr_fin_c4", fin[0], 0);
    chk("rr_busy_c4", busy[0], 0);
    run_decode(36'hF_FFF0_0000);
    chk("rr_c_first", fpos[2], 20);
    chk("rr_a_none", none[0], 1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
